lfsr_d_stepper: RTL and testbench
=================================

// Module: lfsr_d_stepper
// PURPOSE
//  Bidirectional stepping engine for the 56-bit Romulus-N domain/block counter D.
//  Steps D forward (one LFSR clock) or backward (inverse LFSR clock) N times per command.
//  Sits beside the mode FSM and lets it rewind D after a truncated/aborted message and re-seek it.
//  Forward: D'[i]=D[i-1] (i=1..55), D'[0]=D[55]; then D'[7], D'[4], D'[2] ^= D[55].
//  Backward: D[55]=D'[0]; D[i-1]=D'[i] ^ (i in {2,4,7} ? D'[0] : 0) for i=1..55.
// PARAMETERS
//  STEP_W  16        width of cmd_steps (max steps per command = 2^STEP_W-1)
//  INIT    56'h80    counter start value (bit 7 set); reset and underflow reference
//  POS_W   24        width of pos output (only meaningful with LFSR_D_POS_TRACK_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       high only in IDLE; command accepted on cmd_valid&cmd_ready
//  cmd_load   in   1       1: load load_val; 0: step
//  cmd_dir    in   1       0: forward, 1: backward (ignored when cmd_load=1)
//  cmd_steps  in   STEP_W  number of steps (ignored when cmd_load=1)
//  load_val   in   56      value for load command
//  d_out      out  56      current counter value
//  done       out  1       one-cycle pulse: command finished (normally or with error)
//  err        out  1       sticky; set on illegal load or underflow; cleared by next accepted command
//  pos        out  POS_W   signed step index relative to INIT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, d_out=INIT, done=0, err=0, pos=0, cmd_ready=1.
//  FSM: IDLE -> (accept) -> RUN or DONE; RUN -> DONE; DONE -> IDLE (exactly one cycle).
//  Accept edge: err cleared; remaining<=cmd_steps.
//   load, load_val!=0: d_out<=load_val at accept edge, go DONE.
//   load, load_val==0: d_out unchanged, err<=1, go DONE (all-zero state is illegal).
//   step, cmd_steps==0: d_out unchanged, go DONE.
//   step, cmd_steps=N>0: go RUN; one step applied per RUN edge; remaining decrements;
//    edge applying the last step moves to DONE. Final d_out visible N edges after accept.
//  done=1 exactly while in DONE; cmd_ready=0 in RUN and DONE (N+1 cycles busy for N>0).
//  Underflow: backward step in RUN while d_out==INIT -> no step applied, err<=1,
//   remaining discarded, go DONE. Forward steps never underflow; period wrap is legal.
//  cmd_valid while busy is ignored (not queued); inputs sampled only at accept edge.
//  rst_n asserted mid-RUN aborts immediately to reset values; no done pulse.
//  Forward/backward logic is pure combinational on d_out; one step per cycle, no unrolling.
// CONFIGURATION
//  LFSR_D_POS_TRACK_EN defined: pos counts +1 per forward step, -1 per backward step
//   (two's complement, wraps at POS_W); reset to 0 on reset or any successful load.
//  LFSR_D_POS_TRACK_EN undefined: pos tied to 0, no counter logic synthesised.
// TESTING
//  Reset, then fwd N=1 -> d_out=56'h100 two cycles later, done pulse once, err=0.
//  Load 56'h1, bwd N=1 -> d_out=56'h8000000000004A; then fwd N=1 -> d_out=56'h1.
//  From INIT: fwd N=1000 then bwd N=1000 -> d_out=INIT, err=0; pos=0 (with macro).
//  From INIT: bwd N=5 -> underflow on first RUN edge: d_out=INIT, err=1, done next cycle.
//  Load 56'h0 -> err=1, d_out unchanged; step N=0 -> done after 1 cycle, err cleared.
//  rst_n pulsed mid fwd N=50 -> d_out=INIT, cmd_ready=1 immediately, no done.

Source files
------------

// File: rtl/lfsr_d_stepper.sv
// Bidirectional stepping engine for the 56-bit Romulus-N domain/block counter D.
// Optional position tracking is enabled by defining LFSR_D_POS_TRACK_EN.
module lfsr_d_stepper #(
  parameter int          STEP_W = 16,
  parameter logic [55:0] INIT   = 56'h80,
  parameter int          POS_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [55:0]       load_val,
  output logic [55:0]       d_out,
  output logic              done,
  output logic              err,
  output logic [POS_W-1:0]  pos,
  output logic [1:0]        state_dbg
);

  // Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and requests seen while busy are dropped.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [55:0]       d_q, d_fwd, d_bwd;
  logic [STEP_W-1:0] rem_q;
  logic              dir_q, err_q;
  logic              accept, underflow, step_en, load_ok;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign load_ok   = accept && cmd_load && (load_val != '0);
  // Stepping backward past the start value would leave the legal counter range.
  assign underflow = (state == S_RUN) && dir_q && (d_q == INIT);
  assign step_en   = (state == S_RUN) && !underflow;

  always_comb begin
    d_fwd    = {d_q[54:0], d_q[55]};
    d_fwd[2] = d_q[1] ^ d_q[55];
    d_fwd[4] = d_q[3] ^ d_q[55];
    d_fwd[7] = d_q[6] ^ d_q[55];
  end

  // Inverse clock: the old MSB reappears at bit 0 of the current value.
  always_comb begin
    d_bwd       = {d_q[0], d_q[55:1]};
    d_bwd[1]    = d_q[2] ^ d_q[0];
    d_bwd[3]    = d_q[4] ^ d_q[0];
    d_bwd[6]    = d_q[7] ^ d_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = (cmd_load || (cmd_steps == '0)) ? S_DONE : S_RUN;
      S_RUN:  if (underflow || (rem_q == STEP_W'(1))) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= INIT;
      rem_q <= '0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      rem_q <= cmd_steps;
      dir_q <= cmd_dir;
      err_q <= cmd_load && (load_val == '0);
      if (load_ok) d_q <= load_val;
    end else if (underflow) begin
      err_q <= 1'b1;
      rem_q <= '0;
    end else if (step_en) begin
      d_q   <= dir_q ? d_bwd : d_fwd;
      rem_q <= rem_q - STEP_W'(1);
    end
  end

  assign d_out = d_q;
  assign err   = err_q;

`ifdef LFSR_D_POS_TRACK_EN
  logic [POS_W-1:0] pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pos_q <= '0;
    else if (load_ok) pos_q <= '0;
    else if (step_en) pos_q <= dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
  end

  assign pos = pos_q;
`else
  assign pos = '0;
`endif

endmodule

// File: tb/tb_lfsr_d_stepper.sv
// Directed and randomised bench for lfsr_d_stepper with an expected-value scoreboard.
module tb_lfsr_d_stepper;
  localparam int          STEP_W = 16;
  localparam int          POS_W  = 24;
  localparam logic [55:0] INIT   = 56'h80;
  localparam logic [55:0] TAPS   = 56'h94;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_load, cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [55:0]       load_val, d_out;
  logic              done, err;
  logic [POS_W-1:0]  pos;
  logic [1:0]        state_dbg;

  lfsr_d_stepper #(.STEP_W(STEP_W), .INIT(INIT), .POS_W(POS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .load_val(load_val), .d_out(d_out), .done(done), .err(err), .pos(pos),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  logic [55:0]      exp_q[$];
  logic             exp_err_q[$];
  int               exp_lat_q[$];
  logic [POS_W-1:0] exp_pos_q[$];

  logic [55:0]      model_d   = INIT;
  logic [POS_W-1:0] model_pos = '0;

  function automatic logic [55:0] f_fwd(input logic [55:0] d);
    logic [55:0] x;
    x = {d[54:0], d[55]};
    if (d[55]) x = x ^ TAPS;
    return x;
  endfunction

  function automatic logic [55:0] f_bwd(input logic [55:0] d);
    logic [55:0] x;
    x = d[0] ? (d ^ TAPS) : d;
    return {x[0], x[55:1]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic ld, input logic dir, input logic [STEP_W-1:0] n,
                        input logic [55:0] val, input logic poke);
    logic [55:0]      ed;
    logic             ee;
    int               el;
    int               lat;
    logic [POS_W-1:0] ep;
    ee = 1'b0;
    ed = model_d;
    if (ld) begin
      el = 1;
      if (val == '0) ee = 1'b1;
      else begin ed = val; model_pos = '0; end
    end else begin
      el = int'(n) + 1;
      for (int i = 0; i < int'(n); i++) begin
        if (dir && ed == INIT) begin ee = 1'b1; el = i + 2; break; end
        ed = dir ? f_bwd(ed) : f_fwd(ed);
        model_pos = dir ? model_pos - 1'b1 : model_pos + 1'b1;
      end
    end
    model_d = ed;
`ifdef LFSR_D_POS_TRACK_EN
    ep = model_pos;
`else
    ep = '0;
`endif
    exp_q.push_back(ed);
    exp_err_q.push_back(ee);
    exp_lat_q.push_back(el);
    exp_pos_q.push_back(ep);

    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_dir = dir; cmd_steps = n; load_val = val;
    @(posedge clk);
    #1;
    if (poke) begin cmd_load = 1'b1; load_val = 56'hDEAD_BEEF; end
    else cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !done) check("ready_busy", cmd_ready, 0);
    end while (!done && lat < 5000);
    cmd_valid = 1'b0;
    check("latency", lat, exp_lat_q.pop_front());
    check("d_out", d_out, exp_q.pop_front());
    check("err", err, exp_err_q.pop_front());
    check("pos", pos, exp_pos_q.pop_front());
    @(negedge clk);
    check("done_pulse", done, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  initial begin
    logic [55:0] rv, mid;
    logic        seen_done;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; load_val = '0;
    repeat (3) @(negedge clk);
    check("rst_d", d_out, INIT);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pos", pos, 0);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    do_cmd(1'b0, 1'b0, 16'd1, '0, 1'b0);
    check("fwd1_value", d_out, 56'h100);

    do_cmd(1'b1, 1'b0, 16'd0, 56'h1, 1'b0);
    do_cmd(1'b0, 1'b1, 16'd1, '0, 1'b0);
    check("bwd1_value", d_out, 56'h80_0000_0000_004A);
    do_cmd(1'b0, 1'b0, 16'd1, '0, 1'b0);
    check("fwd_back_value", d_out, 56'h1);

    do_cmd(1'b1, 1'b0, 16'd0, INIT, 1'b0);
    do_cmd(1'b0, 1'b0, 16'd1000, '0, 1'b0);
    do_cmd(1'b0, 1'b1, 16'd1000, '0, 1'b0);
    check("roundtrip_value", d_out, INIT);

    do_cmd(1'b0, 1'b1, 16'd5, '0, 1'b0);
    check("underflow_err", err, 1);

    do_cmd(1'b1, 1'b0, 16'd0, 56'h0, 1'b0);
    check("zero_load_err", err, 1);
    do_cmd(1'b0, 1'b0, 16'd0, '0, 1'b0);
    check("zero_steps_err_clr", err, 0);

    for (int k = 0; k < 6; k++) begin
      rv = {24'($urandom), $urandom};
      if (rv == '0) rv = 56'h1;
      do_cmd(1'b1, 1'b0, 16'd0, rv, 1'b0);
      for (int j = 0; j < 3; j++)
        do_cmd(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)), '0, 1'b0);
    end

    do_cmd(1'b0, 1'b0, 16'd10, '0, 1'b1);
    do_cmd(1'b1, 1'b0, 16'd0, 56'h0, 1'b1);

    mid = model_d;
    for (int i = 0; i < 9; i++) mid = f_fwd(mid);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b0; cmd_steps = 16'd50;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_run_d", d_out, mid);
    rst_n = 1'b0;
    #1;
    check("abort_d", d_out, INIT);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_pos", pos, 0);
    model_d = INIT; model_pos = '0;
    seen_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_abort", seen_done, 0);
    do_cmd(1'b0, 1'b0, 16'd1, '0, 1'b0);
    check("post_abort_fwd", d_out, 56'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
